// File: rtl/uart_imem_loader_pkg.sv
// Shared constants and state encodings for the UART instruction-memory loader.
// DIV is derived from the clock/baud pair through calc_div so every user agrees on it.
package uart_imem_loader_pkg;

  localparam int DEF_CLK_FREQ   = 100_000_000;
  localparam int DEF_BAUD       = 115200;
  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DIV        = DEF_CLK_FREQ / DEF_BAUD;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  typedef enum logic [2:0] {
    LD_IDLE, LD_HDR_LO, LD_HDR_HI, LD_DATA, LD_DONE, LD_ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_imem_loader_rx_byte.sv
// 8N1 byte receiver: 2-flop sync, start-bit glitch rejection at half a bit,
// mid-bit sampling every DIV clocks, one-cycle valid/err pulse after the stop sample.
module uart_rx_byte
  import uart_imem_loader_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          // line back high at mid start bit means it was a glitch
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else cnt_d = cnt_q + CW'(1);
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else cnt_d = cnt_q + CW'(1);
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          valid_d = rx_s2_q;
          err_d   = !rx_s2_q;
          state_d = RX_IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_err   = err_q;
  assign byte_data  = shift_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Serial program loader: word-count header then little-endian words from UART,
// written to consecutive imem addresses while the CPU is held in reset.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  logic       rx_valid, rx_err;
  logic [7:0] rx_data;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .rst_n     (rst),
    .rx        (rx),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .byte_err  (rx_err)
  );

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            idx_q, idx_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  we_q, we_d;

  always_comb begin
    state_d = state_q;
    addr_d  = we_q ? addr_q + ADDR_WIDTH'(1) : addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (start) begin
          state_d = LD_HDR_LO;
          addr_d  = '0;
          idx_d   = '0;
        end
      end
      LD_HDR_LO: begin
        if (!start) state_d = LD_IDLE;
        else if (rx_err) state_d = LD_ERR;
        else if (rx_valid) begin
          cnt_d[7:0] = rx_data;
          state_d    = LD_HDR_HI;
        end
      end
      LD_HDR_HI: begin
        if (!start) state_d = LD_IDLE;
        else if (rx_err) state_d = LD_ERR;
        else if (rx_valid) begin
          cnt_d   = {rx_data, cnt_q[7:0]};
          state_d = ({rx_data, cnt_q[7:0]} != 16'd0) ? LD_DATA : LD_DONE;
        end
      end
      LD_DATA: begin
        if (!start) state_d = LD_IDLE;
        else if (rx_err) state_d = LD_ERR;
        else if (rx_valid) begin
          wdata_d[{idx_q, 3'b000} +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // DONE lands on the same edge the final strobe rises
            we_d  = 1'b1;
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = LD_DONE;
          end
        end
      end
      LD_DONE, LD_ERR: begin
        if (!start) state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign busy         = (state_q == LD_HDR_LO) || (state_q == LD_HDR_HI) || (state_q == LD_DATA);
  assign cpu_rst_hold = busy || (state_q == LD_ERR);
  assign done         = (state_q == LD_DONE);
  assign frame_err    = (state_q == LD_ERR);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader at DIV = 16.
module tb_uart_imem_loader;

  localparam int AW  = 14;
  localparam int DIV = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          rx = 1'b1;
  logic          imem_we, cpu_rst_hold, busy, done, frame_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  int            wr_count = 0;
  logic [AW-1:0] wr_addr [16];
  logic [31:0]   wr_data [16];
  logic          wr_hold [16];
  int            n_bytes = 0;

  uart_imem_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rx          (rx),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_rst_hold(cpu_rst_hold),
    .busy        (busy),
    .done        (done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // write and byte-event monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (imem_we && wr_count < 16) begin
      wr_addr[wr_count] = imem_addr;
      wr_data[wr_count] = imem_wdata;
      wr_hold[wr_count] = cpu_rst_hold;
      wr_count = wr_count + 1;
    end
    if (dut.rx_valid) n_bytes = n_bytes + 1;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
  endtask

  task automatic test_reset();
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", imem_we); end
    n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
    n_checks++; if ({cpu_rst_hold, busy, done, frame_err} !== 4'b0000)
      begin n_fail++; $display("FAIL reset_flags got %b want 0000", {cpu_rst_hold, busy, done, frame_err}); end
  endtask

  task automatic test_load2();
    int base;
    base = wr_count;
    @(negedge clk); start = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({cpu_rst_hold, busy} !== 2'b11) begin n_fail++; $display("FAIL load2_hold_busy got %b want 11", {cpu_rst_hold, busy}); end
    send_hdr(16'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    repeat (4) @(negedge clk);
    n_checks++; if (wr_count - base !== 2) begin n_fail++; $display("FAIL load2_count got %0d want 2", wr_count - base); end
    n_checks++; if ({wr_addr[base], wr_data[base]} !== {14'd0, 32'h12345678})
      begin n_fail++; $display("FAIL load2_w0 got %h@%h want 12345678@0", wr_data[base], wr_addr[base]); end
    n_checks++; if ({wr_addr[base+1], wr_data[base+1]} !== {14'd1, 32'hDEADBEEF})
      begin n_fail++; $display("FAIL load2_w1 got %h@%h want deadbeef@1", wr_data[base+1], wr_addr[base+1]); end
    n_checks++; if ({wr_hold[base], wr_hold[base+1]} !== 2'b10)
      begin n_fail++; $display("FAIL load2_hold_at_strobes got %b want 10", {wr_hold[base], wr_hold[base+1]}); end
    n_checks++; if ({done, cpu_rst_hold, busy} !== 3'b100)
      begin n_fail++; $display("FAIL load2_done got %b want 100", {done, cpu_rst_hold, busy}); end
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL load2_done_clear got %b want 0", done); end
  endtask

  task automatic test_n0();
    int base;
    base = wr_count;
    start = 1'b1;
    repeat (2) @(negedge clk);
    send_hdr(16'd0);
    repeat (4) @(negedge clk);
    n_checks++; if ({done, cpu_rst_hold} !== 2'b10) begin n_fail++; $display("FAIL n0_done_hold got %b want 10", {done, cpu_rst_hold}); end
    n_checks++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL n0_writes got %0d want 0", wr_count - base); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_err();
    int base;
    base = wr_count;
    start = 1'b1;
    repeat (2) @(negedge clk);
    send_hdr(16'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (4) @(negedge clk);
    n_checks++; if ({frame_err, cpu_rst_hold, busy, done} !== 4'b1100)
      begin n_fail++; $display("FAIL ferr_flags got %b want 1100", {frame_err, cpu_rst_hold, busy, done}); end
    send_byte(8'h44, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL ferr_writes got %0d want 0", wr_count - base); end
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({frame_err, cpu_rst_hold} !== 2'b00) begin n_fail++; $display("FAIL ferr_clear got %b want 00", {frame_err, cpu_rst_hold}); end
  endtask

  task automatic test_glitch();
    int nb;
    start = 1'b1;
    repeat (2) @(negedge clk);
    send_hdr(16'd1);
    nb = n_bytes;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if (n_bytes - nb !== 0) begin n_fail++; $display("FAIL glitch_bytes got %0d want 0", n_bytes - nb); end
    n_checks++; if ({busy, done, frame_err} !== 3'b100) begin n_fail++; $display("FAIL glitch_state got %b want 100", {busy, done, frame_err}); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    int base;
    base = wr_count;
    start = 1'b1;
    repeat (2) @(negedge clk);
    send_hdr(16'd3);
    send_word(32'hA5A5_0001);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy, cpu_rst_hold, done} !== 3'b000) begin n_fail++; $display("FAIL abort_idle got %b want 000", {busy, cpu_rst_hold, done}); end
    n_checks++; if (wr_count - base !== 1) begin n_fail++; $display("FAIL abort_writes got %0d want 1", wr_count - base); end
    start = 1'b1;
    repeat (2) @(negedge clk);
    send_hdr(16'd1);
    send_word(32'h44332211);
    repeat (4) @(negedge clk);
    n_checks++; if ({wr_addr[base+1], wr_data[base+1]} !== {14'd0, 32'h44332211})
      begin n_fail++; $display("FAIL abort_reload got %h@%h want 44332211@0", wr_data[base+1], wr_addr[base+1]); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int base;
    start = 1'b1;
    repeat (2) @(negedge clk);
    send_hdr(16'd1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    n_checks++; if ({busy, cpu_rst_hold, imem_we} !== 3'b000)
      begin n_fail++; $display("FAIL arst_flags got %b want 000", {busy, cpu_rst_hold, imem_we}); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    base = wr_count;
    repeat (2) @(negedge clk);
    send_hdr(16'd1);
    send_word(32'hBEBAFECA);
    repeat (4) @(negedge clk);
    n_checks++; if (wr_count - base !== 1) begin n_fail++; $display("FAIL arst_writes got %0d want 1", wr_count - base); end
    n_checks++; if ({wr_addr[base], wr_data[base]} !== {14'd0, 32'hBEBAFECA})
      begin n_fail++; $display("FAIL arst_word got %h@%h want bebafeca@0", wr_data[base], wr_addr[base]); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL arst_done got %b want 1", done); end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_load2();
    test_n0();
    test_frame_err();
    test_glitch();
    test_abort();
    test_async_reset();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Serial program loader for the minisys 32 single-cycle CPU. It receives a word-count header and instruction words over an 8N1 UART line and writes each assembled 32-bit word into consecutive instruction-memory addresses. While a load is in progress it holds the CPU in reset. It is the write side of instruction memory, whose read side is the CPU's instruction fetch, and it sits beside `cpu_top` at board level.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: clk frequency in Hz.
- `BAUD`, 115200: line rate. `DIV = CLK_FREQ/BAUD` (integer division) clocks per bit; `DIV` must be ≥ 4.
- `ADDR_WIDTH`, 14: instruction-memory word-address width (depth `2**ADDR_WIDTH`).

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: program-mode request, a level from a switch. Sampled synchronously.
- `rx` input 1: UART receive line, idle high. Asynchronous; 2-flop synchronised internally.
- `imem_we` output 1: one-cycle write strobe to instruction memory.
- `imem_addr` output ADDR_WIDTH: word address for the write.
- `imem_wdata` output 32: word to write.
- `cpu_rst_hold` output 1: high while loading; ORed into the CPU reset.
- `busy` output 1: high in any receive state.
- `done` output 1: load completed; held until `start` falls.
- `frame_err` output 1: stop-bit error seen; held until `start` falls.

## Operation
- Sub-unit byte receiver:
  - Detects a falling edge on the synchronised `rx` and re-checks it at `DIV/2`; if `rx` is high again, the start is rejected as a glitch.
  - Samples 8 data bits (LSB first) at mid-bit, i.e. every `DIV` clocks, then samples the stop bit.
  - Emits `byte_valid` for 1 cycle with `byte_data` if stop = 1, else emits `byte_err` for 1 cycle.
- Stream format, all fields little-endian: 2-byte word count N, then N words of 4 bytes each.
- FSM states and transitions:
  - IDLE → HDR_LO when `start` = 1.
  - HDR_LO → HDR_HI on a byte.
  - HDR_HI → DATA on a byte if N ≠ 0, else → DONE.
  - DATA: a 2-bit byte index fills `imem_wdata[8i+7:8i]`. On the 4th byte, assert `imem_we` the next cycle; `imem_addr` then increments (wraps mod `2**ADDR_WIDTH`) and the word counter decrements. When the counter reaches 0, go to DONE in the same cycle as the final `imem_we`.
  - DONE → IDLE when `start` = 0.
  - ERR → IDLE when `start` = 0.
- `byte_err` in any receive state → ERR; `frame_err` = 1; no further writes.
- `start` falling in HDR_LO, HDR_HI or DATA aborts to IDLE. Partially assembled words are discarded; words already written remain in memory.
- Entry to HDR_LO clears `imem_addr`, the byte index, `done` and `frame_err`.
- If N > `2**ADDR_WIDTH`, words are written with address wrap; the loader does not clamp N.
- `cpu_rst_hold` = 1 in HDR_LO, HDR_HI, DATA and ERR; 0 in IDLE and DONE. `busy` = 1 in HDR_LO, HDR_HI and DATA only.

## Timing
- Reset values: all outputs 0; FSM in IDLE; receiver idle.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously); a partial byte is dropped.
- `rx` path latency: 2 sync flops.
- `byte_valid` rises 1 cycle after the stop-bit sample.
- `imem_we` is registered and rises exactly 1 cycle after the 4th `byte_valid`. `imem_addr` and `imem_wdata` are stable during the strobe cycle; `imem_addr` changes on the following edge.
- Back-to-back bytes with zero idle gap are supported: the receiver re-arms right after the stop-bit sample.
- `start` and a byte event in the same cycle with `start` = 0: abort wins and the byte is ignored.

## Structure
- Put `DIV`, the FSM state encodings (`LD_IDLE`, `LD_HDR_LO`, `LD_HDR_HI`, `LD_DATA`, `LD_DONE`, `LD_ERR`) and the default baud/frequency constants in the shared `definitions.v`.
- One sub-module, `uart_rx_byte`, containing the sync, bit counter, sample timer and shift register, with outputs `byte_valid`, `byte_data` and `byte_err`. The loader FSM stays in the top.

## Test plan
Bench parameters: `CLK_FREQ` = 16, `BAUD` = 1 (`DIV` = 16).
- Load 2 words: `start` = 1, send 02 00, 78 56 34 12, EF BE AD DE → writes 0x12345678 @0 then 0xDEADBEEF @1; `done` = 1; `cpu_rst_hold` 1→0 on the final strobe.
- N = 0: send 00 00 → DONE with no `imem_we`; `cpu_rst_hold` = 0.
- Frame error: stop bit 0 on the 3rd data byte → ERR, `frame_err` = 1, no write. `start` = 0 → IDLE and flags clear.
- Glitch: `rx` low for 4 clocks → no byte emitted, state unchanged.
- Abort: `start` = 0 after 2 of 4 data bytes → IDLE with no write. A reload then starts at address 0.
- Async reset mid-byte, then a full 1-word load → correct write at address 0.
